// File: rtl/clk_div_scan_if.sv
// rtl/clk_div_scan_if.sv - control and display bundle for the clock divider / digit scanner
interface clk_div_scan_if #(
   parameter int unsigned CNT_W  = 26,
   parameter int unsigned DIGITS = 4,
   parameter int unsigned SEL_W  = 2
) ();
   logic              en;
   logic              div_load;
   logic [CNT_W-1:0]  div_val;
   logic              tick;
   logic              slow_clk;
   logic [SEL_W-1:0]  digit_sel;
   logic [DIGITS-1:0] an_n;
   logic              div_pending;

   modport master (
      output en, div_load, div_val,
      input  tick, slow_clk, digit_sel, an_n, div_pending
   );

   modport slave (
      input  en, div_load, div_val,
      output tick, slow_clk, digit_sel, an_n, div_pending
   );
endinterface

// File: rtl/clk_div_scan.sv
// rtl/clk_div_scan.sv - programmable divider producing a tick, a slow square wave and a digit scan
module clk_div_scan #(
   parameter int unsigned CNT_W   = 26,
   parameter int unsigned DEF_DIV = 100000,
   parameter int unsigned DIGITS  = 4,
   parameter int unsigned SEL_W   = 2
) (
   input logic          clk,
   input logic          reset,
   clk_div_scan_if.slave bus
);

   localparam logic [CNT_W-1:0]  DIV_RST  = CNT_W'(DEF_DIV);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(DIGITS - 1);
   localparam logic [DIGITS-1:0] AN_ONE   = DIGITS'(1);

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  div_cur_q, div_cur_d;
   logic [CNT_W-1:0]  div_pend_q, div_pend_d;
   logic              pending_q, pending_d;
   logic              tick_q, tick_d;
   logic              slow_q, slow_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [DIGITS-1:0] an_n_q, an_n_d;
   logic              tc;

   assign tc = bus.en && (cnt_q == (div_cur_q - CNT_ONE));

   always_comb begin
      cnt_d      = cnt_q;
      div_cur_d  = div_cur_q;
      div_pend_d = div_pend_q;
      pending_d  = pending_q;
      tick_d     = 1'b0;
      slow_d     = slow_q;
      sel_d      = sel_q;
      an_n_d     = an_n_q;

      if (tc) begin
         cnt_d  = '0;
         tick_d = 1'b1;
         slow_d = ~slow_q;
         sel_d  = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
         an_n_d = ~(AN_ONE << sel_d);
         // A load on the boundary edge defers application to the following boundary.
         if (pending_q && !bus.div_load) begin
            div_cur_d = div_pend_q;
            pending_d = 1'b0;
         end
      end else if (bus.en) begin
         cnt_d = cnt_q + CNT_ONE;
      end

      if (bus.div_load) begin
         div_pend_d = (bus.div_val == '0) ? CNT_ONE : bus.div_val;
         pending_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q      <= '0;
         div_cur_q  <= DIV_RST;
         div_pend_q <= DIV_RST;
         pending_q  <= 1'b0;
         tick_q     <= 1'b0;
         slow_q     <= 1'b0;
         sel_q      <= '0;
         an_n_q     <= ~AN_ONE;
      end else begin
         cnt_q      <= cnt_d;
         div_cur_q  <= div_cur_d;
         div_pend_q <= div_pend_d;
         pending_q  <= pending_d;
         tick_q     <= tick_d;
         slow_q     <= slow_d;
         sel_q      <= sel_d;
         an_n_q     <= an_n_d;
      end
   end

   assign bus.tick        = tick_q;
   assign bus.slow_clk    = slow_q;
   assign bus.digit_sel   = sel_q;
   assign bus.an_n        = an_n_q;
   assign bus.div_pending = pending_q;

endmodule

// File: doc/clk_div_scan.md
CLK_DIV_SCAN -- requirements
Module: clk_div_scan

Parameters
REQ-001 The block SHALL have parameter CNT_W, default 26, giving the divider counter and divisor width in bits.
REQ-002 The block SHALL have parameter DEF_DIV, default 100000, giving the divisor loaded at reset; legal range is 1..2^CNT_W-1.
REQ-003 The block SHALL have parameter DIGITS, default 4, giving the number of display digits scanned; legal range is 2..16.
REQ-004 The block SHALL have parameter SEL_W, default 2, giving the digit-select width; the integrator SHALL set it to clog2(DIGITS).

Interface
REQ-005 clk  in  1  -- the single clock; all state updates on its rising edge.
REQ-006 reset  in  1  -- synchronous, active-high reset.
REQ-007 en  in  1  -- count enable; while low, the divider and scan state hold.
REQ-008 div_load  in  1  -- single-cycle request to stage a new divisor.
REQ-009 div_val  in  CNT_W  -- divisor value sampled when div_load=1.
REQ-010 tick  out  1  -- registered pulse, one clk cycle wide, once per divide period.
REQ-011 slow_clk  out  1  -- registered square wave that toggles on every tick; period is 2*div_cur.
REQ-012 digit_sel  out  SEL_W  -- index of the active digit.
REQ-013 an_n  out  DIGITS  -- active-low one-hot digit enable; bit digit_sel is 0, all other bits are 1.
REQ-014 div_pending  out  1  -- high while a staged divisor awaits application.

Function
REQ-015 The block SHALL hold internal registers cnt[CNT_W], div_cur[CNT_W] and div_pend[CNT_W].
REQ-016 Terminal count (TC) SHALL be defined as en=1 and cnt==div_cur-1.
REQ-017 On a clock edge with en=1 and no TC, the block SHALL set cnt<=cnt+1 and tick<=0.
REQ-018 On a TC edge, the block SHALL set cnt<=0, tick<=1 and slow_clk<=~slow_clk.
REQ-019 On a TC edge, digit_sel SHALL advance by 1, wrapping from DIGITS-1 to 0; it SHALL never take a value >= DIGITS.
REQ-020 On an edge with en=0, the block SHALL set tick<=0 and hold cnt, slow_clk, digit_sel and an_n.
REQ-021 With en held at 1, the block SHALL produce exactly one tick per div_cur clocks.
REQ-022 With div_cur=1, tick SHALL be held high continuously.
REQ-023 an_n SHALL be registered and updated on the same edge as digit_sel, so the two never disagree.
REQ-024 A div_load=1 edge SHALL capture div_pend<=div_val, with a value of 0 replaced by 1, and SHALL set div_pending<=1.
REQ-025 div_load SHALL be accepted regardless of en.
REQ-026 A second div_load while div_pending=1 SHALL overwrite div_pend (last write wins).
REQ-027 On a TC edge with div_pending=1, the block SHALL set div_cur<=div_pend and div_pending<=0; a new divisor therefore only takes effect at a period boundary, so no short or truncated period is produced.
REQ-028 If div_load and TC occur on the same edge, the block SHALL NOT apply the new value at that TC; it SHALL capture it and apply it at the next TC, leaving div_pending=1 after the edge.
REQ-029 The block SHALL NOT change div_cur at any edge other than a TC edge.
REQ-030 All arithmetic SHALL be unsigned modulo 2^CNT_W; cnt SHALL never exceed div_cur-1.

Reset
REQ-031 A reset edge SHALL set cnt=0, div_cur=DEF_DIV, div_pend=DEF_DIV, div_pending=0, tick=0, slow_clk=0, digit_sel=0 and an_n={all 1s except bit0=0}.
REQ-032 Reset SHALL take priority over en, div_load and TC on the same edge.
REQ-033 Reset asserted mid-period SHALL discard any partial count and pending divisor; the first tick after reset release SHALL occur DEF_DIV enabled clocks later.

Verification (DEF_DIV=4, DIGITS=4, CNT_W=8)
REQ-034 Stimulus: reset, then en=1 for 16 clocks -> tick high on clocks 4, 8, 12, 16 only; slow_clk toggles at each tick; digit_sel goes 1,2,3,0; an_n goes 1101,1011,0111,1110.
REQ-035 Stimulus: div_load with div_val=2 at clock 2 -> div_pending=1 until the clock-4 tick; subsequent ticks at 6, 8, 10.
REQ-036 Stimulus: div_load with div_val=0 -> treated as 1; after the next TC, tick is continuously high.
REQ-037 Stimulus: div_load with div_val=6 on the same edge as a TC -> that period stays 4, the next period is 4, then periods are 6.
REQ-038 Stimulus: en=0 for 5 clocks mid-period -> no tick; cnt, digit_sel and slow_clk frozen; the count resumes from the held value when en returns to 1.
REQ-039 Stimulus: reset pulse at cnt=2 with div_pending=1 -> all outputs return to reset values; the first tick occurs 4 clocks after release with div_cur=4.
